clk_div_gen: RTL and testbench

- Multi-channel programmable clock/enable generator. Runs in the DCM-derived fast clock domain and replaces fixed DCM divider outputs (ADC encode, SPI bit clock, and similar) with register-programmable divided clocks and clock enables.
- Each channel has its own divide ratio and phase offset; all channels are mutually phase-aligned.
- Outputs are gated by a qualified lock from the upstream DCM. Lock losses are counted.

---
 rtl/clk_div_gen.sv | 96 +++++++++
 tb/tb_clk_div_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_gen.sv
// clk_div_gen: lock-qualified multi-channel programmable clock divider and enable generator
module clk_div_gen #(
  parameter int NCH         = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int LOCK_CNT    = 256,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     LOCKED_IN,
  input  logic [NCH*DIV_WIDTH-1:0] DIV,
  input  logic [NCH*DIV_WIDTH-1:0] PHASE,
  input  logic                     LOAD,
  output logic [NCH-1:0]           CLK_OUT,
  output logic [NCH-1:0]           CE_OUT,
  output logic                     LOCKED,
  output logic [7:0]               UNLOCK_CNT
);
  localparam int SW = LOCK_CNT > 1 ? $clog2(LOCK_CNT) : 1;
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;
  typedef logic [NCH-1:0][DIV_WIDTH-1:0] cfg_t;
  state_t state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [1:0] sync_q, sync_d;
  logic [7:0] unlock_q, unlock_d;
  cfg_t div_q, div_d, ph_q, ph_d, cnt_q, cnt_d;
  logic [NCH-1:0] clk_q, clk_d, ce_q, ce_d;
  logic locked_q, locked_d, lk_s, run_d, restart, en;
  logic [DIV_WIDTH-1:0] p;
  always_comb begin
    sync_d = {sync_q[0], LOCKED_IN};
    lk_s = sync_q[1];
    state_d = state_q;
    settle_d = settle_q;
    unlock_d = unlock_q;
    unique case (state_q)
      WAIT_LOCK: if (lk_s) begin
        state_d = SETTLE;
        settle_d = '0;
      end
      SETTLE: if (!lk_s) state_d = WAIT_LOCK;
        else if (settle_q == SW'(LOCK_CNT - 1)) state_d = RUN;
        else settle_d = settle_q + SW'(1);
      RUN: if (!lk_s) begin
        state_d = WAIT_LOCK;
        unlock_d = unlock_q + {7'd0, unlock_q != 8'hff};
      end
      default: state_d = WAIT_LOCK;
    endcase
    run_d = state_d == RUN;
    // every channel restarts together on RUN entry or on LOAD, keeping them phase-aligned
    restart = state_q != RUN || LOAD;
    div_d = LOAD ? cfg_t'(DIV) : div_q;
    ph_d = LOAD ? cfg_t'(PHASE) : ph_q;
    locked_d = run_d;
    en = 1'b0;
    p = '0;
    for (int i = 0; i < NCH; i++) begin
      en = div_d[i] >= DIV_WIDTH'(2);
      p = ph_d[i] < div_d[i] ? ph_d[i] : '0;
      cnt_d[i] = !(run_d && en) ? '0 : restart ? p :
                 cnt_q[i] == div_d[i] - DIV_WIDTH'(1) ? '0 : cnt_q[i] + DIV_WIDTH'(1);
      clk_d[i] = run_d && en && cnt_d[i] < (div_d[i] >> 1);
      ce_d[i] = run_d && en && cnt_d[i] == '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= WAIT_LOCK;
      settle_q <= '0;
      sync_q <= '0;
      unlock_q <= '0;
      div_q <= {NCH{DIV_WIDTH'(DEFAULT_DIV)}};
      ph_q <= '0;
      cnt_q <= '0;
      clk_q <= '0;
      ce_q <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q <= state_d;
      settle_q <= settle_d;
      sync_q <= sync_d;
      unlock_q <= unlock_d;
      div_q <= div_d;
      ph_q <= ph_d;
      cnt_q <= cnt_d;
      clk_q <= clk_d;
      ce_q <= ce_d;
      locked_q <= locked_d;
    end
  end
  assign CLK_OUT = clk_q;
  assign CE_OUT = ce_q;
  assign LOCKED = locked_q;
  assign UNLOCK_CNT = unlock_q;
endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed stimulus with a cycle-level behavioural model of clk_div_gen
module tb_clk_div_gen;
  localparam int NCH = 4;
  localparam int W = 8;
  localparam int LC = 256;
  logic clk = 1'b0, rst = 1'b1, locked_in = 1'b0, load = 1'b0;
  logic [NCH*W-1:0] div = {NCH{8'd4}}, phase = '0;
  logic [NCH-1:0] clk_out, ce_out;
  logic locked;
  logic [7:0] unlock_cnt;
  int checks = 0, errors = 0;
  clk_div_gen #(.NCH(NCH), .DIV_WIDTH(W), .LOCK_CNT(LC), .DEFAULT_DIV(4)) dut (
    .CLK(clk), .RST(rst), .LOCKED_IN(locked_in), .DIV(div), .PHASE(phase), .LOAD(load),
    .CLK_OUT(clk_out), .CE_OUT(ce_out), .LOCKED(locked), .UNLOCK_CNT(unlock_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: RUN holds once lk_s has been seen high for LC+1 consecutive edges;
  // each channel counter is (p + cycles since restart) mod D
  int streak = 0, k = 0, unl = 0, p = 0, c = 0;
  bit run = 0, prev_run = 0, l1 = 0, l2 = 0, started = 0;
  int md[NCH], mp[NCH];
  logic [NCH-1:0] m_clk = '0, m_ce = '0;
  always @(posedge clk) begin
    if (rst) begin
      streak = 0;
      run = 0;
      unl = 0;
      k = 0;
      l1 = 0;
      l2 = 0;
      for (int i = 0; i < NCH; i++) begin
        md[i] = 4;
        mp[i] = 0;
      end
      started = 1;
    end else begin
      prev_run = run;
      streak = l2 ? streak + 1 : 0;
      run = streak >= LC + 1;
      if (prev_run && !l2 && unl < 255) unl++;
      if (load)
        for (int i = 0; i < NCH; i++) begin
          md[i] = int'(div[i*W +: W]);
          mp[i] = int'(phase[i*W +: W]);
        end
      k = (run && (!prev_run || load)) ? 0 : k + 1;
      l2 = l1;
      l1 = locked_in;
    end
    for (int i = 0; i < NCH; i++) begin
      p = mp[i] < md[i] ? mp[i] : 0;
      c = md[i] >= 2 ? (p + k) % md[i] : 0;
      m_ce[i] = run && md[i] >= 2 && c == 0;
      m_clk[i] = run && md[i] >= 2 && c < md[i] / 2;
    end
  end
  always @(negedge clk)
    if (started) chk("outputs{clk,ce,locked,unlock}", {15'd0, clk_out, ce_out, locked, unlock_cnt},
                     {15'd0, m_clk, m_ce, run, unl[7:0]});
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_load(input logic [NCH*W-1:0] d, input logic [NCH*W-1:0] ph);
    div = d;
    phase = ph;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  task automatic drop;
    locked_in = 1'b0;
    @(negedge clk);
    locked_in = 1'b1;
  endtask
  task automatic wait_lock(output int n);
    n = 0;
    while (!locked && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!locked) chk("wait_lock_timeout", 32'(locked), 32'd1);
  endtask
  initial begin
    int n;
    logic [7:0] cb, eb;
    logic [3:0] acc;
    step(3);
    rst = 1'b0;
    step(2);
    chk("reset_locked", 32'(locked), 32'd0);
    chk("reset_unlock", 32'(unlock_cnt), 32'd0);
    chk("reset_outs", {24'd0, clk_out, ce_out}, 32'd0);
    locked_in = 1'b1;
    @(posedge clk);
    n = 0;
    while (!locked && n < 400) begin
      @(posedge clk);
      n++;
      #1;
    end
    chk("lock_latency", 32'(n), 32'd258);
    for (int j = 0; j < 8; j++) begin
      cb[j] = clk_out[0];
      eb[j] = ce_out[0];
      @(posedge clk);
      #1;
    end
    chk("ch0_clk_pattern", 32'(cb), 32'h33);
    chk("ch0_ce_pattern", 32'(eb), 32'h11);
    @(negedge clk);
    pulse_load({8'd4, 8'd5, 8'd5, 8'd4}, {8'd1, 8'd0, 8'd2, 8'd0});
    chk("ch1_after_load", {30'd0, clk_out[1], ce_out[1]}, 32'd0);
    chk("ch2_after_load", {30'd0, clk_out[2], ce_out[2]}, 32'd3);
    step(3);
    chk("ch1_first_ce", 32'(ce_out[1]), 32'd1);
    step(5);
    pulse_load({8'd255, 8'd6, 8'd0, 8'd1}, {8'd254, 8'd9, 8'd0, 8'd0});
    chk("ch2_phase_clamped", {30'd0, clk_out[2], ce_out[2]}, 32'd3);
    chk("ch3_p254", {30'd0, clk_out[3], ce_out[3]}, 32'd0);
    acc = '0;
    repeat (20) begin
      acc |= {clk_out[1:0], ce_out[1:0]};
      step(1);
    end
    chk("disabled_channels", 32'(acc), 32'd0);
    drop;
    step(1);
    chk("locked_before_loss", 32'(locked), 32'd1);
    step(1);
    chk("locked_after_loss", 32'(locked), 32'd0);
    chk("unlock_after_loss", 32'(unlock_cnt), 32'd1);
    chk("outs_after_loss", {24'd0, clk_out, ce_out}, 32'd0);
    wait_lock(n);
    chk("relock_latency", 32'(n), 32'd257);
    step(5);
    drop;
    step(10);
    drop;
    step(3);
    wait_lock(n);
    chk("settle_drop_no_count", 32'(unlock_cnt), 32'd2);
    repeat (260) begin
      drop;
      step(3);
      wait_lock(n);
    end
    chk("unlock_saturated", 32'(unlock_cnt), 32'd255);
    step(4);
    rst = 1'b1;
    div = {NCH{8'd7}};
    load = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_unlock", 32'(unlock_cnt), 32'd0);
    chk("rst_outs", {24'd0, clk_out, ce_out}, 32'd0);
    wait_lock(n);
    chk("rst_relock_latency", 32'(n), 32'd259);
    chk("rst_default_div_first", {24'd0, clk_out, ce_out}, 32'hFF);
    step(2);
    chk("rst_default_div_cnt2", {24'd0, clk_out, ce_out}, 32'h00);
    step(2);
    chk("rst_default_div_wrap", 32'(ce_out), 32'hF);
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
